// File: rtl/banked_byte_mem.sv
// Banked byte-lane memory: one 8-bit bank per lane, word = LANES bytes.
// Requests arrive on a req/busy handshake; each burst beat is paced by a
// down-counter and reported with a one-cycle done pulse (plus last on the
// final beat). Array contents are not reset; control and outputs are.

// Single byte bank: write-enable gated storage plus a registered read port.
module banked_byte_mem_lane #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [7:0]       wdata_i,
    output logic [7:0]       rdata_o
);
    logic [7:0] bank_q [DEPTH];
    logic [7:0] rdata_q;

    // Storage write; held off during reset so an aborted burst commits nothing.
    always_ff @(posedge clk) begin
        if (!reset && we_i) bank_q[idx_i] <= wdata_i;
    end

    // Read register; keeps its value until the next read beat.
    always_ff @(posedge clk) begin
        if (reset)     rdata_q <= '0;
        else if (re_i) rdata_q <= bank_q[idx_i];
    end

    assign rdata_o = rdata_q;
endmodule

module banked_byte_mem #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 1024,
    parameter int BURST_BITS = 2,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memReq,
    input  logic                  memWr,
    input  logic [ADDR_W-1:0]     memAddr,
    input  logic [BURST_BITS-1:0] memBurstLen,
    input  logic [DATA_W-1:0]     memDataIn,
    input  logic [DATA_W/8-1:0]   memStrb,
    output logic                  memBusyOut,
    output logic                  memBeatDone,
    output logic                  memLast,
    output logic [DATA_W-1:0]     memDataOut,
    output logic                  memErr
);
    localparam int LANES   = DATA_W / 8;
    localparam int LSB     = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] RD_CNT0 = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_CNT0 = CNT_W'(WR_LATENCY - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state_q, state_d;
    logic                  wr_q, wr_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BURST_BITS-1:0] beats_q, beats_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  last_q, last_d;
    logic                  err_q, err_d;

    // Full word index; bits above IDX_W only feed the range check.
    logic [ADDR_W-1:0] widx;
    logic              out_of_range;
    logic              fire;

    assign widx         = memAddr >> LSB;
    assign out_of_range = (widx >= ADDR_W'(DEPTH));
    assign fire         = (state_q == BUSY) && (cnt_q == '0);

    // Next-state: accept in IDLE, count down latency and step beats in BUSY.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        beats_d = beats_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        last_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (memReq) begin
                    if (out_of_range) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = BUSY;
                        wr_d    = memWr;
                        idx_d   = widx[IDX_W-1:0];
                        beats_d = memBurstLen;
                        cnt_d   = memWr ? WR_CNT0 : RD_CNT0;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    done_d = 1'b1;
                    last_d = (beats_q == '0);
                    if (beats_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        beats_d = beats_q - 1'b1;
                        idx_d   = idx_q + 1'b1;  // power-of-2 depth: wraps to 0
                        cnt_d   = wr_q ? WR_CNT0 : RD_CNT0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            beats_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            beats_q <= beats_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    genvar i;
    generate
        for (i = 0; i < LANES; i++) begin : g_lane
            banked_byte_mem_lane #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lane (
                .clk     (clk),
                .reset   (reset),
                .we_i    (fire && wr_q && memStrb[i]),
                .re_i    (fire && !wr_q),
                .idx_i   (idx_q),
                .wdata_i (memDataIn[8*i +: 8]),
                .rdata_o (memDataOut[8*i +: 8])
            );
        end
    endgenerate

    assign memBusyOut  = (state_q == BUSY);
    assign memBeatDone = done_q;
    assign memLast     = last_q;
    assign memErr      = err_q;
endmodule

// File: tb/tb_banked_byte_mem.sv
// Directed bench for banked_byte_mem with default parameters
// (32-bit words, 1024 words, latency 2 for reads and writes).
module tb_banked_byte_mem;
    logic        clk = 1'b0;
    logic        reset;
    logic        memReq, memWr;
    logic [31:0] memAddr;
    logic [1:0]  memBurstLen;
    logic [31:0] memDataIn;
    logic [3:0]  memStrb;
    logic        memBusyOut, memBeatDone, memLast, memErr;
    logic [31:0] memDataOut;

    int ncmp = 0;
    int nerr = 0;
    int n;

    banked_byte_mem dut (
        .clk(clk), .reset(reset), .memReq(memReq), .memWr(memWr),
        .memAddr(memAddr), .memBurstLen(memBurstLen), .memDataIn(memDataIn),
        .memStrb(memStrb), .memBusyOut(memBusyOut), .memBeatDone(memBeatDone),
        .memLast(memLast), .memDataOut(memDataOut), .memErr(memErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns at the negedge after the accept edge.
    task automatic start(input logic wr, input logic [31:0] addr, input logic [1:0] len,
                         input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        memReq = 1'b1; memWr = wr; memAddr = addr; memBurstLen = len;
        memDataIn = d; memStrb = s;
        @(negedge clk);
        memReq = 1'b0;
    endtask

    // Count negedges until memBeatDone is seen; bounded.
    task automatic wait_beat(output int cnt);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            cnt++;
            if (memBeatDone) break;
        end
        if (!memBeatDone) begin
            nerr++;
            $display("FAIL beat_timeout: observed no memBeatDone, required one within 20 cycles");
        end
    endtask

    task automatic single_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        start(1'b0, addr, 2'd0, 32'h0, 4'h0);
        wait_beat(n);
        chk({tag, "_lat"}, n, 2);
        chk(tag, memDataOut, exp);
    endtask

    initial begin
        reset = 1'b1; memReq = 1'b0; memWr = 1'b0; memAddr = '0;
        memBurstLen = '0; memDataIn = '0; memStrb = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", memBusyOut, 0);
        chk("rst_done", memBeatDone, 0);
        chk("rst_last", memLast, 0);
        chk("rst_err", memErr, 0);
        chk("rst_data", memDataOut, 0);
        reset = 1'b0;

        // Single full-word write
        start(1'b1, 32'h10, 2'd0, 32'hDEADBEEF, 4'hF);
        chk("w1_busy", memBusyOut, 1);
        wait_beat(n);
        chk("w1_lat", n, 2);
        chk("w1_last", memLast, 1);
        chk("w1_busy_drop", memBusyOut, 0);
        @(negedge clk);
        chk("w1_done_pulse", memBeatDone, 0);
        single_read("r1", 32'h10, 32'hDEADBEEF);

        // Partial strobe write
        start(1'b1, 32'h10, 2'd0, 32'h11223344, 4'b0101);
        wait_beat(n);
        single_read("r_strb", 32'h10, 32'hDE22BE44);

        // 4-beat write burst of 0..3 at 0x20, data advanced after each done
        start(1'b1, 32'h20, 2'd3, 32'd0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            wait_beat(n);
            chk("wb_lat", n, 2);
            chk("wb_last", memLast, (k == 3) ? 1 : 0);
            memDataIn = k + 1;
        end

        // 4-beat read burst
        start(1'b0, 32'h20, 2'd3, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            wait_beat(n);
            chk("rb_lat", n, 2);
            chk("rb_data", memDataOut, k);
            chk("rb_last", memLast, (k == 3) ? 1 : 0);
        end
        chk("rb_idle", memBusyOut, 0);

        // Wrap from last word to word 0
        start(1'b1, 32'd4092, 2'd1, 32'hAAAA0001, 4'hF);
        chk("wrap_err", memErr, 0);
        wait_beat(n);
        memDataIn = 32'hBBBB0002;
        wait_beat(n);
        chk("wrap_last", memLast, 1);
        single_read("wrap_w1023", 32'd4092, 32'hAAAA0001);
        single_read("wrap_w0", 32'd0, 32'hBBBB0002);

        // Out-of-range start
        start(1'b1, 32'd4096, 2'd0, 32'h12345678, 4'hF);
        chk("oor_err", memErr, 1);
        chk("oor_busy", memBusyOut, 0);
        @(negedge clk);
        chk("oor_err_pulse", memErr, 0);
        chk("oor_busy2", memBusyOut, 0);

        // Preload 0x40,0x44 with zero, then reset during a 4-beat write after beat 0
        start(1'b1, 32'h40, 2'd1, 32'h0, 4'hF);
        wait_beat(n);
        wait_beat(n);
        start(1'b1, 32'h40, 2'd3, 32'h000000A0, 4'hF);
        wait_beat(n);
        memDataIn = 32'h000000A1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", memBusyOut, 0);
        chk("abort_done", memBeatDone, 0);
        chk("abort_last", memLast, 0);
        chk("abort_data", memDataOut, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_quiet", memBeatDone, 0);
        single_read("abort_w0", 32'h40, 32'h000000A0);
        single_read("abort_w1", 32'h44, 32'h0);

        // memReq held high across a burst: second burst accepted when busy drops
        @(negedge clk);
        memReq = 1'b1; memWr = 1'b0; memAddr = 32'h10; memBurstLen = 2'd0;
        @(negedge clk);
        memAddr = 32'h40;
        chk("hold_busy", memBusyOut, 1);
        @(negedge clk);
        chk("hold_no_done", memBeatDone, 0);
        @(negedge clk);
        chk("hold_done1", memBeatDone, 1);
        chk("hold_data1", memDataOut, 32'hDE22BE44);
        chk("hold_idle", memBusyOut, 0);
        @(negedge clk);
        memReq = 1'b0;
        chk("hold_reaccept", memBusyOut, 1);
        wait_beat(n);
        chk("hold_lat2", n, 2);
        chk("hold_data2", memDataOut, 32'h000000A0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
